// File: rtl/router_out_arbiter.sv
// Round-robin output arbiter: grants one of three router FIFOs for bursts of up
// to BURST_MAX bytes, with per-channel starvation timeouts.
module router_out_arbiter #(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned TIMEOUT   = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] vld_in,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  input  logic [7:0] data_in_2,
  output logic [2:0] read_enb,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [1:0] dout_ch,
  output logic [2:0] timeout_err
);

  localparam logic [3:0] LP_BURST_LAST = 4'(BURST_MAX - 1);
  localparam logic [7:0] LP_WAIT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SERVE
  } state_t;

  state_t          r_state;
  logic [1:0]      r_grant;
  logic [1:0]      r_rr_ptr;
  logic [3:0]      r_burst_cnt;
  logic [2:0][7:0] r_wait;
  logic [2:0]      r_timeout;

  logic            w_serve;
  logic            w_grant_vld;
  logic            w_xfer;
  logic            w_exit;
  logic [7:0]      w_head;
  logic [1:0]      w_pick;
  logic [1:0]      w_rr_next;

  assign w_serve     = (r_state == ST_SERVE);
  assign w_grant_vld = vld_in[r_grant];
  assign w_xfer      = w_serve & w_grant_vld & dout_ready;
  assign w_exit      = w_serve & ((w_xfer & (r_burst_cnt == LP_BURST_LAST))
                                  | ~w_grant_vld
                                  | r_timeout[r_grant]);
  assign w_rr_next   = (r_grant == 2'd2) ? 2'd0 : r_grant + 2'd1;

  always_comb begin
    w_head = '0;
    case (r_grant)
      2'd0:    w_head = data_in_0;
      2'd1:    w_head = data_in_1;
      default: w_head = data_in_2;
    endcase
  end

  // Search order starts at r_rr_ptr and wraps modulo 3.
  always_comb begin
    w_pick = '0;
    case (r_rr_ptr)
      2'd1: begin
        if (vld_in[1])      w_pick = 2'd1;
        else if (vld_in[2]) w_pick = 2'd2;
        else                w_pick = 2'd0;
      end
      2'd2: begin
        if (vld_in[2])      w_pick = 2'd2;
        else if (vld_in[0]) w_pick = 2'd0;
        else                w_pick = 2'd1;
      end
      default: begin
        if (vld_in[0])      w_pick = 2'd0;
        else if (vld_in[1]) w_pick = 2'd1;
        else                w_pick = 2'd2;
      end
    endcase
  end

  // Outputs are combinational so a pop happens in the same cycle dout_ready is seen.
  assign read_enb    = w_xfer ? (3'b001 << r_grant) : '0;
  assign dout        = w_serve ? w_head : '0;
  assign dout_valid  = w_serve & w_grant_vld;
  assign dout_ch     = r_grant;
  assign timeout_err = r_timeout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|vld_in) begin
            r_grant     <= w_pick;
            r_burst_cnt <= '0;
            r_state     <= ST_SERVE;
          end
        end
        default: begin
          if (w_xfer) r_burst_cnt <= r_burst_cnt + 4'd1;
          if (w_exit) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_rr_next;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait    <= '0;
      r_timeout <= '0;
    end else begin
      for (int unsigned c = 0; c < 3; c++) begin
        if (vld_in[c] && !read_enb[c]) begin
          if (r_wait[c] == LP_WAIT_LAST) begin
            r_wait[c]    <= '0;
            r_timeout[c] <= 1'b1;
          end else begin
            r_wait[c]    <= r_wait[c] + 8'd1;
            r_timeout[c] <= 1'b0;
          end
        end else begin
          r_wait[c]    <= '0;
          r_timeout[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Self-checking bench for router_out_arbiter: fixed vector tables, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_router_out_arbiter;

  localparam int BURST_MAX = 4;
  localparam int TIMEOUT   = 30;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] vld_in;
  logic [7:0] data_in_0, data_in_1, data_in_2;
  logic [2:0] read_enb;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [1:0] dout_ch;
  logic [2:0] timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  router_out_arbiter #(.BURST_MAX(BURST_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .vld_in(vld_in),
    .data_in_0(data_in_0), .data_in_1(data_in_1), .data_in_2(data_in_2),
    .read_enb(read_enb), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_ch(dout_ch), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: arbitration, burst and starvation rules in plain integers.
  bit       m_serve;
  bit       m_granted;
  int       m_g, m_rr, m_cnt;
  int       m_wait [3];
  bit [2:0] m_tmo;
  logic [2:0] e_re;
  logic       e_dv;
  logic [7:0] e_dout;

  task automatic model_reset();
    m_serve = 0; m_granted = 0; m_g = 0; m_rr = 0; m_cnt = 0; m_tmo = '0;
    for (int c = 0; c < 3; c++) m_wait[c] = 0;
  endtask

  task automatic model_eval();
    logic [7:0] dsel;
    dsel = (m_g == 0) ? data_in_0 : (m_g == 1) ? data_in_1 : data_in_2;
    e_dv   = m_serve ? vld_in[m_g] : 1'b0;
    e_dout = m_serve ? dsel : 8'h00;
    e_re   = (m_serve && e_dv && dout_ready) ? 3'(1 << m_g) : 3'b000;
  endtask

  task automatic model_step();
    bit       xfer, leave, found;
    bit [2:0] nt;
    int       ch;
    model_eval();
    xfer  = (e_re != 0);
    leave = m_serve && ((xfer && m_cnt == BURST_MAX - 1) || !vld_in[m_g] || m_tmo[m_g]);
    nt = '0;
    for (int c = 0; c < 3; c++) begin
      if (vld_in[c] && !e_re[c]) begin
        if (m_wait[c] == TIMEOUT - 1) begin m_wait[c] = 0; nt[c] = 1; end
        else m_wait[c]++;
      end else m_wait[c] = 0;
    end
    m_tmo = nt;
    if (!m_serve) begin
      if (vld_in != 0) begin
        found = 0;
        for (int i = 0; i < 3; i++) begin
          ch = (m_rr + i) % 3;
          if (!found && vld_in[ch]) begin m_g = ch; found = 1; end
        end
        m_cnt = 0; m_serve = 1; m_granted = 1;
      end
    end else begin
      if (xfer) m_cnt++;
      if (leave) begin m_serve = 0; m_rr = (m_g + 1) % 3; end
    end
  endtask

  task automatic model_check(input string tag);
    model_eval();
    chk({tag, "_read_enb"}, read_enb, e_re);
    chk({tag, "_dout_valid"}, dout_valid, e_dv);
    chk({tag, "_dout"}, dout, e_dout);
    if (m_serve) chk({tag, "_dout_ch"}, dout_ch, m_g);
    else if (!m_granted) chk({tag, "_dout_ch"}, dout_ch, 0);
    chk({tag, "_timeout_err"}, timeout_err, m_tmo);
  endtask

  logic [2:0] obs_re, obs_tmo;

  // Drive at posedge+1, check at posedge+3, advance model on the next edge.
  task automatic cycle(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic r, input string tag);
    vld_in = v; data_in_0 = a; data_in_1 = b; data_in_2 = c; dout_ready = r;
    #2;
    model_check(tag);
    obs_re = read_enb; obs_tmo = timeout_err;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    vld_in = 3'b111; data_in_0 = 8'hFF; data_in_1 = 8'hEE; data_in_2 = 8'hDD; dout_ready = 1'b1;
    model_reset();
    #2;
    chk("rst_read_enb", read_enb, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_dout_ch", dout_ch, 0);
    chk("rst_timeout_err", timeout_err, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [2:0] v;
    logic [7:0] d0, d1, d2;
    logic       r;
    logic [2:0] re;
    logic       dv;
    logic [7:0] dout;
    logic [1:0] ch;
    logic       ch_care;
    logic [2:0] tmo;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] v, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic r, input logic [2:0] re,
                              input logic dv, input logic [7:0] dout, input logic [1:0] ch,
                              input logic ch_care);
    vec_t t;
    t.v = v; t.d0 = d0; t.d1 = d1; t.d2 = d2; t.r = r; t.re = re; t.dv = dv;
    t.dout = dout; t.ch = ch; t.ch_care = ch_care; t.tmo = 3'b000;
    return t;
  endfunction

  task automatic run_table(input vec_t tbl [$], input string tag);
    foreach (tbl[i]) begin
      vld_in = tbl[i].v; data_in_0 = tbl[i].d0; data_in_1 = tbl[i].d1;
      data_in_2 = tbl[i].d2; dout_ready = tbl[i].r;
      #2;
      chk($sformatf("%s[%0d]_read_enb", tag, i), read_enb, tbl[i].re);
      chk($sformatf("%s[%0d]_dout_valid", tag, i), dout_valid, tbl[i].dv);
      chk($sformatf("%s[%0d]_dout", tag, i), dout, tbl[i].dout);
      if (tbl[i].ch_care) chk($sformatf("%s[%0d]_dout_ch", tag, i), dout_ch, tbl[i].ch);
      chk($sformatf("%s[%0d]_timeout_err", tag, i), timeout_err, tbl[i].tmo);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vec_t single [$];
    vec_t rr [$];
    logic [7:0] dd [3];
    int pops, first_tmo, n_tmo, thr, ch;

    // Single requester on ch1, then rr_ptr=2 prefers ch2 over ch0.
    for (int k = 0; k < 5; k++)
      single.push_back(mk(3'b010, 8'h00, 8'hA5, 8'h00, 1'b1,
                          (k == 0) ? 3'b000 : 3'b010, k != 0, (k == 0) ? 8'h00 : 8'hA5,
                          (k == 0) ? 2'd0 : 2'd1, 1'b1));
    single.push_back(mk(3'b101, 8'h5A, 8'hA5, 8'hC3, 1'b1, 3'b000, 1'b0, 8'h00, 2'd0, 1'b0));
    single.push_back(mk(3'b101, 8'h5A, 8'hA5, 8'hC3, 1'b1, 3'b100, 1'b1, 8'hC3, 2'd2, 1'b1));

    // All channels requesting: bursts of 4 in order 0,1,2,0 with one idle bubble each.
    dd[0] = 8'h10; dd[1] = 8'h21; dd[2] = 8'h32;
    for (int k = 0; k < 20; k++) begin
      ch = (k / 5) % 3;
      if (k % 5 == 0)
        rr.push_back(mk(3'b111, dd[0], dd[1], dd[2], 1'b1, 3'b000, 1'b0, 8'h00, 2'd0, k == 0));
      else
        rr.push_back(mk(3'b111, dd[0], dd[1], dd[2], 1'b1, 3'(1 << ch), 1'b1, dd[ch],
                        2'(ch), 1'b1));
    end

    do_reset();
    run_table(single, "single");
    do_reset();
    run_table(rr, "rr");

    // Back-pressure mid-burst on ch0: no pops while stalled, burst still totals 4.
    do_reset();
    pops = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(3'b001, 8'(8'h40 + pops), 8'h00, 8'h00, 1'b1, "stall");
      if (obs_re[0]) pops++;
    end
    for (int k = 0; k < 5; k++) begin
      cycle(3'b001, 8'(8'h40 + pops), 8'h00, 8'h00, 1'b0, "stall");
      if (obs_re[0]) pops++;
    end
    for (int k = 0; k < 2; k++) begin
      cycle(3'b001, 8'(8'h40 + pops), 8'h00, 8'h00, 1'b1, "stall");
      if (obs_re[0]) pops++;
    end
    cycle(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, "stall_end");
    chk("stall_total_pops", pops, 4);

    // ch2 runs dry after 2 pops: early exit, rr_ptr wraps to 0.
    do_reset();
    pops = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(3'b100, 8'h00, 8'h00, 8'(8'h70 + pops), 1'b1, "dry");
      if (obs_re[2]) pops++;
    end
    cycle(3'b000, 8'h00, 8'h00, 8'h00, 1'b1, "dry_drop");
    if (obs_re != 0) pops++;
    chk("dry_pops", pops, 2);
    cycle(3'b111, 8'h01, 8'h02, 8'h03, 1'b0, "dry_idle");
    #2;
    chk("dry_next_grant", dout_ch, 0);
    cycle(3'b111, 8'h01, 8'h02, 8'h03, 1'b0, "dry_serve");

    // Starved ch0 with dout_ready low: timeout pulse in cycle 30, then rr_ptr=1.
    do_reset();
    first_tmo = -1; n_tmo = 0;
    for (int k = 0; k <= 30; k++) begin
      cycle(3'b001, 8'h66, 8'h77, 8'h88, 1'b0, "tmo");
      if (obs_tmo[0]) begin n_tmo++; if (first_tmo < 0) first_tmo = k; end
    end
    chk("tmo_first_cycle", first_tmo, 30);
    chk("tmo_pulse_count", n_tmo, 1);
    cycle(3'b011, 8'h66, 8'h77, 8'h88, 1'b0, "tmo_idle");
    #2;
    chk("tmo_next_grant", dout_ch, 1);
    for (int k = 0; k < 80; k++) cycle(3'b001, 8'h66, 8'h77, 8'h88, 1'b0, "tmo_repeat");

    // Asynchronous reset during the second pop.
    do_reset();
    cycle(3'b111, 8'h90, 8'h91, 8'h92, 1'b1, "arst");
    cycle(3'b111, 8'h90, 8'h91, 8'h92, 1'b1, "arst");
    #2;
    chk("arst_pre_read_enb", read_enb, 3'b001);
    resetn = 1'b0;
    #1;
    chk("arst_read_enb", read_enb, 0);
    chk("arst_dout_valid", dout_valid, 0);
    chk("arst_dout", dout, 0);
    chk("arst_dout_ch", dout_ch, 0);
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("arst_hold_read_enb", read_enb, 0);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cycle(3'b110, 8'h90, 8'h91, 8'h92, 1'b1, "arst_rel");
    #2;
    chk("arst_first_grant", dout_ch, 1);
    cycle(3'b110, 8'h90, 8'h91, 8'h92, 1'b1, "arst_rel");

    // Randomized traffic with varying back-pressure phases.
    do_reset();
    thr = 5;
    for (int k = 0; k < 3000; k++) begin
      if (k % 150 == 0) thr = $urandom_range(0, 10);
      cycle({($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8)},
            8'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 9) < thr), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
